// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared main memory between I-cache and D-cache: 8-word block fills and D-side write-through stores.
// Optional define MEM_ARB_RR_EN: alternate winner on simultaneous requests (otherwise fixed D-over-I priority).
module mem_fill_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BLK_W   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     i_grant,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_grant,
  output logic                     d_done,
  output logic                     fill_valid,
  output logic [$clog2(BLK_W)-1:0] fill_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_valid
);
  localparam int IDX_W = $clog2(BLK_W);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * BLK_W - 1);
  localparam logic [IDX_W:0]    ISS_END   = (IDX_W + 1)'(BLK_W);
  localparam logic [IDX_W-1:0]  RET_LAST  = IDX_W'(BLK_W - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    iss_q, iss_d;
  logic [IDX_W-1:0]  ret_q, ret_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] iss_off;
  logic              pick_i;

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_fill_arbiter: MEM_LAT must be at least 1");
  end

  assign iss_off = {{(ADDR_W - IDX_W - 1){1'b0}}, iss_q[IDX_W-1:0], 1'b0};

`ifdef MEM_ARB_RR_EN
  logic last_d_q;  // 1 = D side won the most recent arbitration

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && state_d != IDLE) begin
      last_d_q <= (state_d != I_FILL);
    end
  end

  assign pick_i = i_req & last_d_q;
`else
  assign pick_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  always_comb begin
    state_d    = state_q;
    iss_d      = iss_q;
    ret_d      = ret_q;
    base_d     = base_q;
    i_grant    = (state_q == I_FILL);
    d_grant    = (state_q == D_FILL) || (state_q == D_WRITE);
    i_done     = 1'b0;
    d_done     = 1'b0;
    fill_valid = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        iss_d = '0;
        ret_d = '0;
        if (d_req && !pick_i) begin
          if (d_wr) begin
            state_d = D_WRITE;
          end else begin
            state_d = D_FILL;
            base_d  = d_addr & BASE_MASK;
          end
        end else if (i_req) begin
          state_d = I_FILL;
          base_d  = i_addr & BASE_MASK;
        end
      end
      I_FILL, D_FILL: begin
        // Issue and return counters run independently; memory latency sits between them.
        if (iss_q < ISS_END) begin
          mem_en   = 1'b1;
          mem_addr = base_q + iss_off;
          iss_d    = iss_q + 1'b1;
        end
        if (mem_valid) begin
          fill_valid = 1'b1;
          fill_idx   = ret_q;
          fill_data  = mem_rdata;
          ret_d      = ret_q + 1'b1;
          if (ret_q == RET_LAST) begin
            i_done  = (state_q == I_FILL);
            d_done  = (state_q == D_FILL);
            state_d = IDLE;
          end
        end
      end
      D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: latency-exact memory responder plus a transaction-level timeline/priority model.
module tb_mem_fill_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n, i_req, d_req, d_wr, mem_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_grant, i_done, d_grant, d_done, fill_valid, mem_en, mem_wr;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data, mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t        pend[$];
  logic [15:0] mem_q [0:32767];
  logic [15:0] wr_map [int];
  bit          last_win_i = 1'b1;

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_W(8), .MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32768; i++) mem_q[i] = {i[14:0], 1'b0} ^ 16'hC3A5;
  end

  // Memory: a read seen in cycle c returns its word in cycle c+L.
  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_wr === 1'b0) pend.push_back('{due: cyc + L, data: mem_q[mem_addr[15:1]]});
    if (mem_en === 1'b1 && mem_wr === 1'b1) mem_q[mem_addr[15:1]] = mem_wdata;
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_valid = 1'b1;
      mem_rdata = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (wr_map.exists(int'(a))) return wr_map[int'(a)];
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_grants"}, 32'({i_grant, d_grant}), 32'd0);
    chk({tag, "_en_wr"}, 32'({mem_en, mem_wr}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_fv_done"}, 32'({fill_valid, i_done, d_done}), 32'd0);
    chk({tag, "_fill_idx"}, 32'(fill_idx), 32'd0);
    chk({tag, "_fill_data"}, 32'(fill_data), 32'd0);
  endtask

  // Called at posedge+1 with the request already driven; returns at posedge+1.
  task automatic serve_fill(input bit sd, input logic [15:0] addr, input int drop_at, input int exp_wait);
    int          w;
    logic [15:0] base, a;
    string       nm;
    w = 0;
    base = addr & 16'hFFF0;
    nm = sd ? "D" : "I";
    @(negedge clk);
    while ((sd ? d_grant : i_grant) !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_entry_wait"}, 32'(w), 32'(exp_wait));
    for (int j = 0; j <= L + 8; j++) begin
      if (j > 0) @(negedge clk);
      chk({nm, "_mem_en"}, 32'(mem_en), 32'(j < 8));
      if (j < 8) begin
        chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(16'(base + 16'(2 * j))));
        chk({nm, "_wr_wdata"}, 32'({mem_wr, mem_wdata}), 32'd0);
      end
      chk({nm, "_fill_valid"}, 32'(fill_valid), 32'(j >= L && j < L + 8));
      if (j >= L && j < L + 8) begin
        a = 16'(base + 16'(2 * (j - L)));
        chk({nm, "_fill_idx"}, 32'(fill_idx), 32'(j - L));
        chk({nm, "_fill_data"}, 32'(fill_data), 32'(exp_word(a)));
      end
      chk({nm, "_own_done"}, 32'(sd ? d_done : i_done), 32'(j == L + 7));
      chk({nm, "_own_grant"}, 32'(sd ? d_grant : i_grant), 32'(j < L + 8));
      chk({nm, "_other"}, 32'(sd ? {i_grant, i_done} : {d_grant, d_done}), 32'd0);
      @(posedge clk);
      #1;
      if (j == drop_at || j == L + 7) begin
        if (sd) d_req = 1'b0;
        else i_req = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] dat);
    d_req = 1'b1; d_wr = 1'b1; d_addr = a; d_wdata = dat;
    @(negedge clk);
    chk("W_idle_before", 32'({d_grant, mem_en}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("W_en_wr", 32'({mem_en, mem_wr}), 32'h3);
    chk("W_mem_addr", 32'(mem_addr), 32'(a));
    chk("W_mem_wdata", 32'(mem_wdata), 32'(dat));
    chk("W_done_grant", 32'({d_done, d_grant, i_grant, fill_valid}), 32'hC);
    wr_map[int'(a)] = dat;
    @(posedge clk); #1;
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    chk("W_idle_after", 32'({d_grant, d_done, mem_en}), 32'd0);
    @(posedge clk); #1;
    last_win_i = 1'b0;
  endtask

  task automatic collide(input logic [15:0] da, input logic [15:0] ia, input int dr);
    bit first_d;
`ifdef MEM_ARB_RR_EN
    first_d = last_win_i;
`else
    first_d = 1'b1;
`endif
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_wr = 1'b0; d_addr = da; d_wdata = 16'($urandom);
    if (first_d) begin
      serve_fill(1'b1, da, dr, 1);
      serve_fill(1'b0, ia, -1, 0);
      last_win_i = 1'b1;
    end else begin
      serve_fill(1'b0, ia, dr, 1);
      serve_fill(1'b1, da, -1, 0);
      last_win_i = 1'b0;
    end
  endtask

  initial begin
    int          r, dr;
    logic [15:0] ra, rb;
    rst_n = 1'b0; i_req = 1'b1; i_addr = 16'h1111;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = 16'h5555;
    mem_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    @(posedge clk); #1;

    i_req = 1'b1; i_addr = 16'h1234;
    serve_fill(1'b0, 16'h1234, -1, 1);
    last_win_i = 1'b1;

    do_write(16'h0042, 16'hBEEF);

    collide(16'h0100, 16'h2200, -1);
    collide(16'h0310, 16'h4456, -1);

    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'hFFFA; d_wdata = 16'h7777;
    serve_fill(1'b1, 16'hFFFA, -1, 1);
    last_win_i = 1'b0;

    // Reset in the middle of an I fill, right after the third returned word.
    i_req = 1'b1; i_addr = 16'h2468;
    @(negedge clk);
    chk("RST_idle_before", 32'(i_grant), 32'd0);
    @(posedge clk); #1;
    for (int j = 0; j <= L + 2; j++) begin
      @(negedge clk);
      chk("RST_grant", 32'(i_grant), 32'd1);
      if (j == L + 2) chk("RST_third_word", 32'({fill_valid, fill_idx}), 32'hA);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_zero("RST_after");
      @(posedge clk); #1;
    end
    last_win_i = 1'b1;

    i_req = 1'b1; i_addr = 16'h5678;
    serve_fill(1'b0, 16'h5678, 1, 1);
    last_win_i = 1'b1;

    do_write(16'h1236, 16'hA5A5);
    i_req = 1'b1; i_addr = 16'h123C;
    serve_fill(1'b0, 16'h123C, -1, 1);
    last_win_i = 1'b1;

    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 3));
      dr = int'($urandom_range(0, 8)) - 1;
      ra = 16'($urandom) & 16'hFFFE;
      rb = 16'($urandom) & 16'hFFFE;
      case (r)
        0: do_write(ra, 16'($urandom));
        1: begin
          i_req = 1'b1; i_addr = ra;
          serve_fill(1'b0, ra, dr, 1);
          last_win_i = 1'b1;
        end
        2: begin
          d_req = 1'b1; d_wr = 1'b0; d_addr = ra; d_wdata = 16'($urandom);
          serve_fill(1'b1, ra, dr, 1);
          last_win_i = 1'b0;
        end
        default: collide(ra, rb, dr);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
